// File: rtl/mux_scan_capture.sv
// Scan sequencer for a 4:1 source mux with a capture FIFO.
// Walks the enabled sources in ascending order and holds each select for a settle time.
// Each muxed byte is pushed into a first-word-fall-through FIFO as {source, data}.
// The FIFO drains over a valid/ready interface.
module mux_scan_capture #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [3:0]    src_mask,
  output logic [1:0]    mux_s,
  input  logic [DW-1:0] y_in,
  output logic          busy,
  output logic          scan_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    out_src
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSettle, StCapture} state_e;

  state_e         state_q;
  logic [SCW-1:0] cnt_q;
  logic [3:0]     mask_q;

  logic [DW+1:0]  mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  logic           fifo_full, push, pop;
  logic [3:0]     above;
  logic           nxt_valid;
  logic [1:0]     nxt_idx, first_idx;
  logic [DW+1:0]  head;

  // Lowest enabled source in the incoming mask, and next enabled source above the current one.
  always_comb begin
    above     = mask_q & (4'b1110 << mux_s);
    nxt_valid = 1'b0;
    nxt_idx   = 2'd0;
    first_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (above[i]) begin
        nxt_valid = 1'b1;
        nxt_idx   = 2'(i);
      end
      if (src_mask[i]) begin
        first_idx = 2'(i);
      end
    end
  end

  assign fifo_full = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  // A full FIFO blocks the push even when a pop frees a slot in the same cycle.
  assign push      = (state_q == StCapture) && !fifo_full;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_src   = out_valid ? head[DW+1:DW] : 2'd0;

  // Scan sequencer: select stepping, settle countdown and capture handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mask_q    <= '0;
      mux_s     <= 2'd0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && (src_mask != 4'd0)) begin
            mask_q  <= src_mask;
            mux_s   <= first_idx;
            cnt_q   <= SCW'(SETTLE);
            busy    <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          cnt_q <= cnt_q - SCW'(1);
          if (cnt_q == SCW'(1)) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          if (!fifo_full) begin
            if (nxt_valid) begin
              mux_s   <= nxt_idx;
              cnt_q   <= SCW'(SETTLE);
              state_q <= StSettle;
            end else begin
              busy      <= 1'b0;
              scan_done <= 1'b1;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the outputs are masked when empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= {mux_s, y_in};
    end
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
// Self-checking bench for mux_scan_capture: two instances (settle 1 and settle 3).
module tb_mux_scan_capture;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start1, start3, out_ready1, out_ready3;
  logic [3:0] src_mask;
  logic [1:0] mux_s1, mux_s3, src1, src3;
  logic [7:0] y1, y3, data1, data3;
  logic       busy1, busy3, done1, done3, out_valid1, out_valid3;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] q1[$];
  logic [9:0] q3[$];
  logic [9:0] e1, e3;

  // Source model for the settle-1 instance: each mux input holds a fixed byte.
  assign y1 = 8'h0A + 8'h11 * {6'd0, mux_s1};

  mux_scan_capture #(.DW(8), .DEPTH(4), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .src_mask(src_mask), .mux_s(mux_s1),
    .y_in(y1), .busy(busy1), .scan_done(done1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(data1), .out_src(src1)
  );

  mux_scan_capture #(.DW(8), .DEPTH(4), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .src_mask(src_mask), .mux_s(mux_s3),
    .y_in(y3), .busy(busy3), .scan_done(done3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(data3), .out_src(src3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop side: compare each accepted head entry against the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("pop1_unexpected", {31'd0, out_valid1}, 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("pop1_src", {30'd0, src1}, {30'd0, e1[9:8]});
        chk("pop1_data", {24'd0, data1}, {24'd0, e1[7:0]});
      end
    end
    if (rst_n && out_valid3 && out_ready3) begin
      if (q3.size() == 0) chk("pop3_unexpected", {31'd0, out_valid3}, 32'd0);
      else begin
        e3 = q3.pop_front();
        chk("pop3_src", {30'd0, src3}, {30'd0, e3[9:8]});
        chk("pop3_data", {24'd0, data3}, {24'd0, e3[7:0]});
      end
    end
  end

  task automatic push_exp1(input logic [3:0] m);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ii;
      ii = 2'(i);
      if (m[i]) q1.push_back({ii, 8'h0A + 8'h11 * {6'd0, ii}});
    end
  endtask

  // One scan on the settle-1 instance with out_ready=1; optional mid-scan disturbance.
  task automatic scan1(input logic [3:0] m, input int exp_busy, input bit disturb,
                       input string tag);
    int nb = 0, nd = 0, nv = 0;
    @(negedge clk);
    src_mask = m;
    start1   = 1'b1;
    push_exp1(m);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) start1 = 1'b0;
      if (disturb && i == 2) begin
        start1   = 1'b1;
        src_mask = 4'b0001;
      end
      if (disturb && i == 3) start1 = 1'b0;
      nb += int'(busy1);
      nd += int'(done1);
      nv += int'(out_valid1);
    end
    chk({tag, "_busy_cycles"}, nb, exp_busy);
    chk({tag, "_done_pulses"}, nd, (exp_busy > 0) ? 1 : 0);
    chk({tag, "_valid_cycles"}, nv, $countones(m));
    chk({tag, "_queue_left"}, q1.size(), 0);
  endtask

  initial begin
    int nd;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; src_mask = 4'd0;
    out_ready1 = 1'b1; out_ready3 = 1'b1; y3 = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_mux_s", {30'd0, mux_s1}, 0);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_done", {31'd0, done1}, 0);
    chk("rst_valid", {31'd0, out_valid1}, 0);
    chk("rst_data", {24'd0, data1}, 0);
    chk("rst_src", {30'd0, src1}, 0);
    chk("rst_busy3", {31'd0, busy3}, 0);
    rst_n = 1'b1;

    // Full mask, then sparse mask, then empty mask.
    scan1(4'b1111, 8, 1'b0, "t1");
    scan1(4'b0101, 4, 1'b0, "t2a");
    scan1(4'b0000, 0, 1'b0, "t2b");

    // Backpressure: two back-to-back scans into a depth-4 FIFO.
    out_ready1 = 1'b0;
    nd = 0;
    @(negedge clk);
    src_mask = 4'b1111;
    start1   = 1'b1;
    push_exp1(4'b1111);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start1 = 1'b0;
      if (i == 8) begin
        chk("t3_idle_between", {31'd0, busy1}, 0);
        start1 = 1'b1;
        push_exp1(4'b1111);
      end
      if (i == 9) start1 = 1'b0;
      nd += int'(done1);
    end
    chk("t3_first_done", nd, 1);
    chk("t3_stall_busy", {31'd0, busy1}, 1);
    chk("t3_stall_mux", {30'd0, mux_s1}, 0);
    chk("t3_stall_valid", {31'd0, out_valid1}, 1);
    out_ready1 = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nd += int'(done1);
    end
    chk("t3_second_done", nd, 1);
    chk("t3_drained", q1.size(), 0);
    chk("t3_idle_end", {31'd0, busy1}, 0);

    // start and src_mask changes mid-scan are ignored.
    scan1(4'b1111, 8, 1'b1, "t4");

    // Reset during settle of source 2 with two entries queued.
    out_ready1 = 1'b0;
    @(negedge clk);
    src_mask = 4'b1111;
    start1   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) start1 = 1'b0;
    end
    chk("t5_pre_mux", {30'd0, mux_s1}, 2);
    chk("t5_pre_valid", {31'd0, out_valid1}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_mux", {30'd0, mux_s1}, 0);
    chk("t5_busy", {31'd0, busy1}, 0);
    chk("t5_valid", {31'd0, out_valid1}, 0);
    chk("t5_data", {24'd0, data1}, 0);
    chk("t5_done", {31'd0, done1}, 0);
    rst_n = 1'b1;
    q1.delete();
    repeat (6) @(negedge clk);
    chk("t5_no_push", {31'd0, out_valid1}, 0);
    chk("t5_still_idle", {31'd0, busy1}, 0);
    out_ready1 = 1'b1;

    // Settle-3 instance: y_in changes every cycle; only the capture-edge value is stored.
    @(negedge clk);
    src_mask = 4'b1111;
    start3   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        start3 = 1'b0;
        y3     = 8'($urandom);
        chk("t6_mux_hold", {30'd0, mux_s3}, j);
        chk("t6_busy", {31'd0, busy3}, 1);
        if (c == 3) q3.push_back({2'(j), y3});
      end
    end
    repeat (10) @(negedge clk);
    chk("t6_drained", q3.size(), 0);
    chk("t6_idle", {31'd0, busy3}, 0);
    chk("t6_mux_final", {30'd0, mux_s3}, 3);

    chk("end_q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
